// File: rtl/bridge_rr_arbiter_if.sv
// Request/response bundle between N_REQ senders, the round-robin arbiter and the bridge receiver.
// slave = arbiter side, master = the environment that drives senders and the receiver.
interface bridge_rr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       in_valid;
  logic [N_REQ*WIDTH-1:0] in_data;
  logic [N_REQ-1:0]       in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_src;
  logic                   out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/bridge_rr_arbiter.sv
// Round-robin N_REQ:1 valid/ready arbiter into a one-deep output register; word visible 1 cycle after handshake.
// Backpressure: in_ready is granted only while the register is empty or draining this cycle; 1 word/cycle sustained.
module bridge_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  bridge_rr_arbiter_if.slave      bus,
  output logic                    o_busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [ID_W-1:0]  r_src;
  logic [ID_W-1:0]  r_rr_ptr;

  logic             w_load_ok;
  logic             w_found;
  logic             w_grant;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [WIDTH-1:0] w_gnt_data;

  assign w_load_ok = i_en & ~i_rst & ((r_state == EMPTY) | bus.out_ready);
  assign w_grant   = w_load_ok & w_found;

  // Scan from rr_ptr upward; wrap is an explicit compare so non-power-of-2 N_REQ works.
  always_comb begin
    logic [ID_W:0] idx;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (!w_found && bus.in_valid[idx[ID_W-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_gnt_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.in_ready[i] = w_grant && (w_gnt_idx == ID_W'(i));
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == ID_W'(N_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant) begin
      w_state_nxt = FULL;
    end else if ((r_state == FULL) && bus.out_ready) begin
      w_state_nxt = EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= EMPTY;
      r_data   <= '0;
      r_src    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_data   <= w_gnt_data;
        r_src    <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.out_valid = (r_state == FULL);
  assign bus.out_data  = r_data;
  assign bus.out_src   = r_src;
  assign o_busy        = (r_state == FULL) | (|bus.in_valid);

endmodule

// File: tb/tb_bridge_rr_arbiter.sv
// Directed bench for bridge_rr_arbiter (N_REQ=4, WIDTH=8) with immediate-assertion checks.
module tb_bridge_rr_arbiter;
  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic clk;
  logic rst;
  logic en;
  logic busy;
  int   n_assert;
  int   n_fail;

  logic [WIDTH-1:0] words [N_REQ];

  bridge_rr_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  bridge_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .bus    (bus.slave),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge, where registered outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    words[0] = 8'h10;
    words[1] = 8'h11;
    words[2] = 8'hA5;
    words[3] = 8'h13;
    bus.in_data   = {words[3], words[2], words[1], words[0]};
    rst           = 1'b1;
    en            = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;

    // 1: reset held two cycles with every requester valid
    #1;
    chk("rst_in_ready_comb", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_src", 32'(bus.out_src), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);

    // 2: single requester 2
    rst           = 1'b0;
    bus.in_valid  = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    chk("single_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("single_out_valid", 32'(bus.out_valid), 32'h1);
    chk("single_out_data", 32'(bus.out_data), 32'hA5);
    chk("single_out_src", 32'(bus.out_src), 32'h2);
    chk("single_rr_ptr", 32'(dut.r_rr_ptr), 32'h3);

    // Requester 3 alone: pointer wraps 3 -> 0
    bus.in_valid = 4'b1000;
    #1;
    chk("wrap_in_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk("wrap_out_src", 32'(bus.out_src), 32'h3);
    chk("wrap_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);

    // 3: all valid, back-to-back grants 0,1,2,3,0,1,2,3
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_in_ready_%0d", k), 32'(bus.in_ready), 32'(1) << (k % 4));
      tick();
      chk($sformatf("rr_out_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      chk($sformatf("rr_out_src_%0d", k), 32'(bus.out_src), 32'(k % 4));
      chk($sformatf("rr_out_data_%0d", k), 32'(bus.out_data), 32'(words[k % 4]));
    end

    // 4: load src=1, then stall the receiver for 5 cycles
    bus.in_valid = 4'b0010;
    #1;
    chk("bp_load_in_ready", 32'(bus.in_ready), 32'h2);
    tick();
    chk("bp_load_src", 32'(bus.out_src), 32'h1);
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), 32'h0);
      tick();
      chk($sformatf("bp_out_valid_%0d", k), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp_out_src_%0d", k), 32'(bus.out_src), 32'h1);
      chk($sformatf("bp_out_data_%0d", k), 32'(bus.out_data), 32'h11);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    chk("bp_release_src", 32'(bus.out_src), 32'h2);
    chk("bp_release_data", 32'(bus.out_data), 32'hA5);

    // 5: en=0 drains the held word, grants nothing, pointer frozen at 3
    en = 1'b0;
    #1;
    chk("en0_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("en0_out_valid", 32'(bus.out_valid), 32'h0);
    chk("en0_in_ready_empty", 32'(bus.in_ready), 32'h0);
    chk("en0_busy", 32'(busy), 32'h1);
    tick();
    chk("en0_out_valid_hold", 32'(bus.out_valid), 32'h0);
    chk("en0_rr_ptr", 32'(dut.r_rr_ptr), 32'h3);
    en = 1'b1;
    #1;
    chk("en1_in_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk("en1_out_valid", 32'(bus.out_valid), 32'h1);
    chk("en1_out_src", 32'(bus.out_src), 32'h3);

    // 6: reset while FULL drops the word
    bus.in_valid  = 4'b1000;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #1;
    chk("rst6_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("rst6_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst6_rr_ptr", 32'(dut.r_rr_ptr), 32'h0);
    chk("rst6_out_src", 32'(bus.out_src), 32'h0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h8);
    tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_out_src", 32'(bus.out_src), 32'h3);
    chk("post_rst_out_data", 32'(bus.out_data), 32'h13);

    // Drain with no requesters: valid drops, data/src hold, block idle
    bus.in_valid = 4'b0000;
    tick();
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain_out_data", 32'(bus.out_data), 32'h13);
    chk("drain_out_src", 32'(bus.out_src), 32'h3);
    chk("drain_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
